// File: rtl/gfx256_pkg.sv
// Shared types for the gfx256 read path: arbiter FSM states and index helpers.
package gfx256_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RELEASE} arb_state_e;

  localparam logic [1:0] ARB_NONE = 2'd3;

  // Successor of a requester index, wrapping 2 -> 0.
  function automatic logic [1:0] arb_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/gfx256_rr_pick.sv
// Combinational 3-way priority pick starting at a pointer; pointer 0 gives
// plain fixed priority with requester 0 highest.
module gfx256_rr_pick
  import gfx256_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic       o_valid,
  output logic [1:0] o_idx
);

  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  assign w_c0 = (i_ptr == ARB_NONE) ? 2'd0 : i_ptr;
  assign w_c1 = arb_next(w_c0);
  assign w_c2 = arb_next(w_c1);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = ARB_NONE;
    if (i_req[w_c0]) begin
      o_valid = 1'b1;
      o_idx   = w_c0;
    end else if (i_req[w_c1]) begin
      o_valid = 1'b1;
      o_idx   = w_c1;
    end else if (i_req[w_c2]) begin
      o_valid = 1'b1;
      o_idx   = w_c2;
    end
  end

endmodule

// File: rtl/gfx256_read_arbiter.sv
// Shares the 256-bit wishbone read master among clip, fragment and blender
// requesters; one grant at a time, held until ack or watchdog expiry.
module gfx256_read_arbiter
  import gfx256_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int RR      = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0][31:0]  addr_i,
  input  logic [NREQ-1:0][31:0]  sel_i,
  output logic [NREQ-1:0]        ack_o,
  output logic [NREQ-1:0]        busy_o,
  output logic [255:0]           data_o,
  output logic                   m_request_o,
  output logic [31:0]            m_addr_o,
  output logic [31:0]            m_sel_o,
  input  logic [255:0]           m_data_i,
  input  logic                   m_ack_i,
  input  logic                   m_busy_i,
  output logic [1:0]             grant_o,
  output logic                   timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_e      r_state;
  arb_state_e      w_state_next;
  logic [1:0]      r_grant;
  logic [1:0]      r_ptr;
  logic [31:0]     r_addr;
  logic [31:0]     r_sel;
  logic [WD_W-1:0] r_wdog;
  logic            r_timeout;

  logic            w_valid;
  logic [1:0]      w_idx;
  logic [1:0]      w_ptr;
  logic            w_take;
  logic            w_expire;
  logic            w_done;
  logic            w_fire;

  assign w_ptr = (RR != 0) ? r_ptr : 2'd0;

  gfx256_rr_pick u_pick (
    .i_req   (req_i),
    .i_ptr   (w_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_expire = (r_state == ARB_BUSY) && (r_wdog == WD_LAST);
  assign w_fire   = !rst_i && (r_state == ARB_BUSY) && (m_ack_i || w_expire);

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_valid && !m_busy_i) begin
          w_take       = 1'b1;
          w_state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (m_ack_i || w_expire) begin
          w_done       = 1'b1;
          w_state_next = ARB_RELEASE;
        end
      end
      ARB_RELEASE: w_state_next = ARB_IDLE;
      default:     w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ARB_IDLE;
      r_grant   <= ARB_NONE;
      r_ptr     <= 2'd0;
      r_addr    <= 32'd0;
      r_sel     <= 32'hFFFF_FFFF;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_grant <= w_idx;
        r_addr  <= addr_i[w_idx];
        r_sel   <= sel_i[w_idx];
        r_wdog  <= '0;
      end else if (r_state == ARB_BUSY && !w_done) begin
        r_wdog <= r_wdog + WD_W'(1);
      end
      // Expiry without an ack is what marks the sticky watchdog flag.
      if (w_done) begin
        r_ptr <= arb_next(r_grant);
        if (!m_ack_i) r_timeout <= 1'b1;
      end
      if (r_state == ARB_RELEASE) r_grant <= ARB_NONE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_port
      assign ack_o[gi]  = w_fire && (r_grant == 2'(gi));
      assign busy_o[gi] = ((r_state != ARB_IDLE) && (r_grant != 2'(gi))) || m_busy_i;
    end
  endgenerate

  assign data_o      = m_data_i;
  assign m_request_o = !rst_i && (r_state == ARB_BUSY);
  assign m_addr_o    = r_addr;
  assign m_sel_o     = r_sel;
  assign grant_o     = r_grant;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_gfx256_read_arbiter.sv
// Scoreboard bench: round-robin DUT (A) and fixed-priority DUT (B), both with an
// 8-cycle watchdog; expected acks are queued at stimulus time and popped by a monitor.
module tb_gfx256_read_arbiter;

  typedef struct {
    logic [2:0]   ack;
    logic [255:0] data;
    logic [1:0]   grant;
  } exp_t;

  localparam logic [31:0] BASE_A = 32'hC0DE_0000;
  localparam logic [31:0] BASE_B = 32'hBEEF_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [2:0]       req_a, req_b;
  logic [2:0][31:0] addr, sel;
  logic [255:0]     m_data_a, m_data_b;
  logic             m_ack_a, m_ack_b;
  logic             m_busy;

  logic [2:0]   ack_a, busy_a, ack_b, busy_b;
  logic [255:0] data_a, data_b;
  logic         m_request_a, m_request_b;
  logic [31:0]  m_addr_a, m_sel_a, m_addr_b, m_sel_b;
  logic [1:0]   grant_a, grant_b;
  logic         timeout_a, timeout_b;

  gfx256_read_arbiter #(.NREQ(3), .RR(1), .TIMEOUT(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .addr_i(addr), .sel_i(sel),
    .ack_o(ack_a), .busy_o(busy_a), .data_o(data_a),
    .m_request_o(m_request_a), .m_addr_o(m_addr_a), .m_sel_o(m_sel_a),
    .m_data_i(m_data_a), .m_ack_i(m_ack_a), .m_busy_i(m_busy),
    .grant_o(grant_a), .timeout_o(timeout_a)
  );

  gfx256_read_arbiter #(.NREQ(3), .RR(0), .TIMEOUT(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .addr_i(addr), .sel_i(sel),
    .ack_o(ack_b), .busy_o(busy_b), .data_o(data_b),
    .m_request_o(m_request_b), .m_addr_o(m_addr_b), .m_sel_o(m_sel_b),
    .m_data_i(m_data_b), .m_ack_i(m_ack_b), .m_busy_i(m_busy),
    .grant_o(grant_b), .timeout_o(timeout_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  // auto-responder state
  bit auto_a, auto_b;
  int cnt_a, cnt_b, dly_a, dly_b, done_a, done_b, tgt_a, tgt_b;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [255:0] pat(input logic [31:0] base, input int k);
    logic [31:0] w;
    w = base | 32'(k);
    return {8{w}};
  endfunction

  task automatic push_a(input logic [2:0] a, input logic [255:0] d, input logic [1:0] g);
    exp_t e;
    e.ack = a; e.data = d; e.grant = g;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [2:0] a, input logic [255:0] d, input logic [1:0] g);
    exp_t e;
    e.ack = a; e.data = d; e.grant = g;
    q_b.push_back(e);
  endtask

  // One clock; afterwards the auto responders ack dly cycles into each request.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_a) begin
      if (m_request_a) begin
        cnt_a++;
        if (cnt_a == dly_a) begin
          m_ack_a  = 1'b1;
          m_data_a = pat(BASE_A, done_a);
          done_a++;
          if (done_a == tgt_a) req_a = 3'b000;
        end else m_ack_a = 1'b0;
      end else begin
        cnt_a = 0; m_ack_a = 1'b0;
      end
    end
    if (auto_b) begin
      if (m_request_b) begin
        cnt_b++;
        if (cnt_b == dly_b) begin
          m_ack_b  = 1'b1;
          m_data_b = pat(BASE_B, done_b);
          done_b++;
          if (done_b == tgt_b) req_b = 3'b000;
        end else m_ack_b = 1'b0;
      end else begin
        cnt_b = 0; m_ack_b = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a = 3'b000; req_b = 3'b000;
    m_ack_a = 1'b0; m_ack_b = 1'b0; m_busy = 1'b0;
    auto_a = 1'b0; auto_b = 1'b0;
    cnt_a = 0; cnt_b = 0; done_a = 0; done_b = 0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Monitor: every ack pulse must match the next queued expectation.
  exp_t ea, eb;
  initial begin
    forever begin
      @(negedge clk);
      if (ack_a != 3'b000) begin
        if (q_a.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL ack_a_unexpected: got %b expected none", ack_a);
        end else begin
          ea = q_a.pop_front();
          check("ack_a_vec", 256'(ack_a), 256'(ea.ack));
          check("ack_a_data", data_a, ea.data);
          check("ack_a_grant", 256'(grant_a), 256'(ea.grant));
        end
      end
      if (ack_b != 3'b000) begin
        if (q_b.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL ack_b_unexpected: got %b expected none", ack_b);
        end else begin
          eb = q_b.pop_front();
          check("ack_b_vec", 256'(ack_b), 256'(eb.ack));
          check("ack_b_data", data_b, eb.data);
          check("ack_b_grant", 256'(grant_b), 256'(eb.grant));
        end
      end
    end
  end

  initial begin
    addr = '0;
    sel = {3{32'hFFFF_FFFF}};
    m_data_a = '0; m_data_b = '0;
    dly_a = 1; dly_b = 1; tgt_a = 0; tgt_b = 0;

    // reset state
    do_reset();
    #1;
    check("rst_grant", 256'(grant_a), 256'(2'd3));
    check("rst_sel", 256'(m_sel_a), 256'(32'hFFFF_FFFF));
    check("rst_addr", 256'(m_addr_a), 256'd0);
    check("rst_request", 256'(m_request_a), 256'd0);
    check("rst_ack", 256'(ack_a), 256'd0);
    check("rst_busy", 256'(busy_a), 256'd0);
    check("rst_timeout", 256'(timeout_a), 256'd0);
    check("rst_data", data_a, 256'd0);
    check("rst_grant_b", 256'(grant_b), 256'(2'd3));

    // single read, address freeze, busy mask
    addr[0] = 32'h100;
    req_a = 3'b001;
    tick(); #1;
    check("t1_request", 256'(m_request_a), 256'd1);
    check("t1_addr", 256'(m_addr_a), 256'h100);
    check("t1_grant", 256'(grant_a), 256'd0);
    check("t3_busy", 256'(busy_a), 256'(3'b110));
    addr[0] = 32'h200;
    tick(); #1;
    check("t3_addr_stable", 256'(m_addr_a), 256'h100);
    check("t3_request_held", 256'(m_request_a), 256'd1);
    m_data_a = {8{32'hA5A5_A5A5}};
    m_ack_a = 1'b1;
    push_a(3'b001, {8{32'hA5A5_A5A5}}, 2'd0);
    #1;
    check("t1_ack_same_cycle", 256'(ack_a), 256'(3'b001));
    tick();
    m_ack_a = 1'b0; req_a = 3'b000;
    #1;
    check("t1_request_drop", 256'(m_request_a), 256'd0);
    check("t1_late_ack_quiet", 256'(ack_a), 256'd0);
    tick(); #1;
    check("t1_grant_none", 256'(grant_a), 256'(2'd3));

    // round-robin (A) versus fixed priority (B), all requests held
    do_reset();
    dly_a = 3; dly_b = 3; tgt_a = 4; tgt_b = 4;
    auto_a = 1'b1; auto_b = 1'b1;
    push_a(3'b001, pat(BASE_A, 0), 2'd0);
    push_a(3'b010, pat(BASE_A, 1), 2'd1);
    push_a(3'b100, pat(BASE_A, 2), 2'd2);
    push_a(3'b001, pat(BASE_A, 3), 2'd0);
    for (int k = 0; k < 4; k++) push_b(3'b001, pat(BASE_B, k), 2'd0);
    req_a = 3'b111; req_b = 3'b111;
    for (int i = 0; i < 100; i++) begin
      if (done_a == 4 && done_b == 4) break;
      tick();
    end
    repeat (4) tick();
    #1;
    check("t2_done_a", 256'(done_a), 256'd4);
    check("t2_done_b", 256'(done_b), 256'd4);
    check("t2_queue_a_empty", 256'(q_a.size()), 256'd0);
    check("t2_queue_b_empty", 256'(q_b.size()), 256'd0);
    check("t2_grant_idle", 256'(grant_a), 256'(2'd3));

    // wbm reader busy blocks the grant
    do_reset();
    m_busy = 1'b1;
    req_a = 3'b010;
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      check("t4_no_request", 256'(m_request_a), 256'd0);
      check("t4_no_grant", 256'(grant_a), 256'(2'd3));
    end
    check("t4_busy_all", 256'(busy_a), 256'(3'b111));
    dly_a = 1; tgt_a = 1; done_a = 0;
    auto_a = 1'b1;
    push_a(3'b010, pat(BASE_A, 0), 2'd1);
    m_busy = 1'b0;
    tick(); #1;
    check("t4_request_next", 256'(m_request_a), 256'd1);
    check("t4_grant", 256'(grant_a), 256'd1);
    for (int i = 0; i < 20; i++) begin
      if (q_a.size() == 0) break;
      tick();
    end
    check("t4_ack_seen", 256'(q_a.size()), 256'd0);

    // watchdog expiry after 8 BUSY cycles
    do_reset();
    m_data_a = {8{32'h5A5A_5A5A}};
    req_a = 3'b100;
    push_a(3'b100, {8{32'h5A5A_5A5A}}, 2'd2);
    tick();
    for (int c = 1; c <= 8; c++) begin
      #1;
      check("t5_request_busy", 256'(m_request_a), 256'd1);
      check("t5_ack_cycle", 256'(ack_a), 256'((c == 8) ? 3'b100 : 3'b000));
      check("t5_timeout_low", 256'(timeout_a), 256'd0);
      if (c == 8) req_a = 3'b000;
      tick();
    end
    #1;
    check("t5_request_drop", 256'(m_request_a), 256'd0);
    check("t5_timeout_set", 256'(timeout_a), 256'd1);
    check("t5_no_second_ack", 256'(ack_a), 256'd0);
    tick(); #1;
    check("t5_idle_grant", 256'(grant_a), 256'(2'd3));
    repeat (3) tick();
    #1;
    check("t5_timeout_sticky", 256'(timeout_a), 256'd1);
    check("t5_queue_empty", 256'(q_a.size()), 256'd0);
    do_reset();
    #1;
    check("t5_timeout_cleared", 256'(timeout_a), 256'd0);

    // reset mid-transfer, then a late ack
    sel[0] = 32'h0000_000F;
    req_a = 3'b001;
    tick(); #1;
    check("t6_request", 256'(m_request_a), 256'd1);
    check("t6_sel_busy", 256'(m_sel_a), 256'h0000_000F);
    rst = 1'b1;
    tick();
    rst = 1'b0; req_a = 3'b000;
    m_data_a = {8{32'hDEAD_BEEF}};
    m_ack_a = 1'b1;
    #1;
    check("t6_no_ack", 256'(ack_a), 256'd0);
    check("t6_grant_none", 256'(grant_a), 256'(2'd3));
    check("t6_sel_reset", 256'(m_sel_a), 256'(32'hFFFF_FFFF));
    check("t6_request_low", 256'(m_request_a), 256'd0);
    tick();
    m_ack_a = 1'b0;
    repeat (2) tick();
    #1;
    check("t6_still_idle", 256'(grant_a), 256'(2'd3));

    repeat (3) tick();
    check("final_queue_a", 256'(q_a.size()), 256'd0);
    check("final_queue_b", 256'(q_b.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
